// File: rtl/mc_cr_pkg.sv
// Shared types, geometry constants and the pixel add/clip helper for the
// chroma motion-compensation reconstruction block.
package mc_cr_pkg;

  // Block geometry and sample widths.
  localparam int MB_SIZE       = 8;              // block edge in pixels, must be even
  localparam int PIXEL_WIDTH   = 8;              // unsigned pixel width
  localparam int RES_WIDTH     = PIXEL_WIDTH + 1; // signed residual width

  // One beat carries a horizontal pixel pair.
  localparam int BEATS_PER_ROW = MB_SIZE / 2;
  localparam int BEATS         = MB_SIZE * MB_SIZE / 2;

  // Index widths derived from the geometry.
  localparam int CNT_W         = $clog2(BEATS);
  localparam int ROW_W         = $clog2(MB_SIZE);
  localparam int COL_W         = $clog2(MB_SIZE);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_e;

  // Reference pixel plus signed residual, saturated to the pixel range.
  // The sum is formed one bit wider than the residual so that the largest
  // positive and negative results both fit without wrapping.
  function automatic logic [PIXEL_WIDTH-1:0] clip_add(
    input logic [PIXEL_WIDTH-1:0] ref_pix,
    input logic [RES_WIDTH-1:0]   res
  );
    logic [RES_WIDTH:0] sum_s;
    sum_s = {{(RES_WIDTH + 1 - PIXEL_WIDTH){1'b0}}, ref_pix}
          + {res[RES_WIDTH-1], res};
    if (sum_s[RES_WIDTH]) begin
      return {PIXEL_WIDTH{1'b0}};
    end else if (|sum_s[RES_WIDTH-1:PIXEL_WIDTH]) begin
      return {PIXEL_WIDTH{1'b1}};
    end else begin
      return sum_s[PIXEL_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/mc_cr_clip_add.sv
// Single-lane reconstruction adder: reference pixel plus signed residual,
// clipped to the unsigned pixel range. Purely combinational.
import mc_cr_pkg::*;

module mc_cr_clip_add (
  input  logic [PIXEL_WIDTH-1:0] ref_pix,
  input  logic [RES_WIDTH-1:0]   res,
  output logic [PIXEL_WIDTH-1:0] pix
);

  // Add and saturate in one combinational step; the caller registers it.
  always_comb begin
    pix = clip_add(ref_pix, res);
  end

endmodule

// File: rtl/mc_cr_recon.sv
// Chroma MC reconstruction: collects a raster-ordered residual stream two
// pixels per beat, adds it to the co-located reference pixels with clipping,
// and presents the completed block until the consumer takes it.
import mc_cr_pkg::*;

module mc_cr_recon (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIXEL_WIDTH-1:0] ref_frame   [MB_SIZE][MB_SIZE],
  input  logic [RES_WIDTH-1:0]   residual_in [2],
  input  logic                   src_valid,
  output logic                   src_ready,
  output logic [PIXEL_WIDTH-1:0] recon       [MB_SIZE][MB_SIZE],
  output logic                   dst_valid,
  input  logic                   dst_ready
);

  state_e                 state_r;
  state_e                 state_next_s;
  logic [CNT_W-1:0]       beat_cnt_r;
  logic                   accept_s;
  logic                   last_beat_s;
  logic [ROW_W-1:0]       row_s;
  logic [COL_W-1:0]       col0_s;
  logic [COL_W-1:0]       col1_s;
  logic [PIXEL_WIDTH-1:0] ref0_s;
  logic [PIXEL_WIDTH-1:0] ref1_s;
  logic [PIXEL_WIDTH-1:0] pix0_s;
  logic [PIXEL_WIDTH-1:0] pix1_s;

  // src_ready is a register that is high exactly while collecting, so it
  // doubles as the "in COLLECT" qualifier for the beat handshake.
  always_comb begin
    accept_s    = src_valid && src_ready;
    last_beat_s = (beat_cnt_r == CNT_W'(BEATS - 1));
  end

  // Raster address of the current beat: row from the quotient, left column
  // from twice the remainder; the right column is its neighbour.
  always_comb begin
    row_s  = ROW_W'(beat_cnt_r / CNT_W'(BEATS_PER_ROW));
    col0_s = COL_W'({beat_cnt_r % CNT_W'(BEATS_PER_ROW), 1'b0});
    col1_s = col0_s + COL_W'(1);
    ref0_s = ref_frame[row_s][col0_s];
    ref1_s = ref_frame[row_s][col1_s];
  end

  mc_cr_clip_add u_lane0 (
    .ref_pix (ref0_s),
    .res     (residual_in[0]),
    .pix     (pix0_s)
  );

  mc_cr_clip_add u_lane1 (
    .ref_pix (ref1_s),
    .res     (residual_in[1]),
    .pix     (pix1_s)
  );

  // Next-state decode: finish a block on its last beat, release it on the
  // output handshake.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      COLLECT: begin
        if (accept_s && last_beat_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = COLLECT;
        end
      end
      DONE: begin
        if (dst_valid && dst_ready) begin
          state_next_s = COLLECT;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = COLLECT;
      end
    endcase
  end

  // State register with handshake outputs registered alongside it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= COLLECT;
      src_ready <= 1'b1;
      dst_valid <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      src_ready <= (state_next_s == COLLECT);
      dst_valid <= (state_next_s == DONE);
    end
  end

  // Beat counter: advances per accepted beat and wraps after the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      if (last_beat_s) begin
        beat_cnt_r <= {CNT_W{1'b0}};
      end else begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end
    end
  end

  // Reconstructed block: cleared on reset, otherwise each accepted beat
  // overwrites its pixel pair; previous block contents persist until then.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < MB_SIZE; r++) begin
        for (int c = 0; c < MB_SIZE; c++) begin
          recon[r][c] <= {PIXEL_WIDTH{1'b0}};
        end
      end
    end else if (accept_s) begin
      recon[row_s][col0_s] <= pix0_s;
      recon[row_s][col1_s] <= pix1_s;
    end
  end

endmodule

// File: doc/mc_cr_recon.md
Name: mc_cr_recon

Overview:
Chroma motion-compensation reconstruction: the inverse of the residual-generation path in mc_cr. Accepts a residual stream two pixels per beat, adds each pair to the co-located pixels of an 8x8 reference block, clips to pixel range and assembles the reconstructed macroblock. Sits in the encoder's reconstruction loop after inverse transform/quant; the output block feeds the reference frame store.

Parameters:
MB_SIZE, 8, block edge in pixels; must be even.
PIXEL_WIDTH, 8, unsigned pixel width.
RES_WIDTH, PIXEL_WIDTH+1, signed two's-complement residual width.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
ref_frame  input  [PIXEL_WIDTH-1:0] x MB_SIZE x MB_SIZE  reference block; held stable from first beat until dst handshake.
residual_in  input  [RES_WIDTH-1:0] x 2  signed residual pair; element 0 is left pixel.
src_valid  input  1  residual_in valid.
src_ready  output  1  block accepts a beat.
recon  output  [PIXEL_WIDTH-1:0] x MB_SIZE x MB_SIZE  reconstructed block (registered).
dst_valid  output  1  recon complete and stable.
dst_ready  input  1  consumer takes recon.

Behaviour:
- Reset (synchronous, active-high): state=COLLECT, beat_cnt=0, every recon pixel=0, dst_valid=0, src_ready=1 from the first cycle after reset. Reset wins over every other event. Reset mid-block discards partial data.
- BEATS = MB_SIZE*MB_SIZE/2 (32 at default). Raster order: beat k writes row k/(MB_SIZE/2), columns 2*(k mod (MB_SIZE/2)) and +1.
- States: COLLECT, DONE.
- COLLECT: src_ready=1, dst_valid=0. Beat accepted when src_valid && src_ready. On accept, write both recon pixels at the addressed position and increment beat_cnt. src_valid low: hold everything; gaps are allowed anywhere.
- Accept of beat BEATS-1: beat_cnt wraps to 0, next state DONE. dst_valid is asserted on the cycle after the last beat is accepted, so latency is 1 cycle.
- DONE: src_ready=0, dst_valid=1, recon frozen. src_valid is ignored and no write occurs.
- dst_valid && dst_ready: next state COLLECT, src_ready=1 on the following cycle. recon keeps its values until overwritten beat by beat; no clear between blocks.
- dst_ready low in DONE: hold indefinitely.
- Because src_ready is 0 in DONE, a new first beat cannot overlap the output handshake; there are no simultaneous-event conflicts.
- Arithmetic: sum = zero-extended ref pixel (RES_WIDTH+1 bits) + sign-extended residual (RES_WIDTH+1 bits).
  - sum < 0 gives 0.
  - sum > 2^PIXEL_WIDTH-1 gives 2^PIXEL_WIDTH-1.
  - Otherwise recon = sum[PIXEL_WIDTH-1:0].
- Purely combinational add/clip feeding the registered write; no extra pipeline stage.

Decomposition:
- Package mc_cr_pkg:
  - state enum {COLLECT, DONE}.
  - localparams BEATS and BEATS_PER_ROW.
  - clip_add function (ref, res) to pixel.
- Sub-module mc_cr_clip_add: one pixel adder/clipper, instantiated twice for lanes 0 and 1.
- Top mc_cr_recon holds the FSM, beat counter, address decode and the recon register array.

Test Plan:
- Flat add: ref all 100, 32 beats of residual {+5,+5}, dst_ready=1 -> dst_valid one cycle after beat 31; recon all 105; src_ready low for exactly 1 cycle.
- Clipping: ref all 250 with residual +10 -> all 255. ref all 3 with residual -10 -> all 0. Residual -256 on ref 255 -> 0.
- Round trip with mc_cr: ref rows 1..64 ascending, residual = curr - ref with curr 64..1 descending (e.g. [0][0]: 64-1=+63; [7][7]: 1-64=-63) -> recon equals curr exactly (recon[0][0]=64, recon[7][7]=1).
- Backpressure and gaps: src_valid toggles every other cycle, then dst_ready low 5 cycles -> all 32 beats still counted correctly; dst_valid stays 1 and recon stable; src_ready=0; extra src_valid beats in DONE cause no writes.
- Reset mid-block: reset after 10 beats -> recon all 0, beat_cnt 0. Next block of 32 beats {+1,+1} on ref 7 -> recon all 8.
- Back-to-back blocks: second block {+2,+2} on ref 7 accepted starting the cycle after the dst handshake -> recon all 9; no beat lost at the boundary.
